dmux4way_dispatcher: RTL and testbench

//  Sequences the 4-way demultiplexer as a stream dispatcher: accepts words on a

---
 rtl/dmux4way_dispatcher.sv | 106 ++++++++++
 tb/tb_dmux4way_dispatcher.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmux4way_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : dmux4way_dispatcher
//  Description : Single-word stream dispatcher. Accepts one word from a
//                valid/ready producer, buffers it, and presents it to exactly
//                one of four valid/ready consumer lanes. The lane is chosen
//                round-robin or from a fixed configured select, and it is
//                latched when the word is accepted.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid/in_ready   - producer handshake
//                in_data             - input word
//                cfg_mode, cfg_sel   - 0 = round-robin, 1 = fixed lane cfg_sel
//                out_valid[3:0]      - one-hot lane valid (registered state)
//                out_ready[3:0]      - per-lane consumer ready
//                out_data            - buffered word, broadcast to all lanes
//                cur_sel             - lane of the buffered word
//                stall               - buffered word waited STALL_LIMIT cycles
//                disp_cnt            - delivered-word counter (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmux4way_dispatcher #(
    parameter int WIDTH       = 8,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_mode,
    input  logic [1:0]       cfg_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       cur_sel,
    output logic             stall,
    output logic [CNT_W-1:0] disp_cnt
);

    localparam int                 c_STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(STALL_LIMIT);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [0:0]           r_state;
    logic [WIDTH-1:0]     r_data;
    logic [1:0]           r_cur_sel;
    logic [1:0]           r_rr_ptr;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0]     r_disp_cnt;

    logic w_deliver;
    logic w_in_ready;
    logic w_accept;

    // Only the selected lane's ready matters; other lanes are ignored so a
    // stalled lane blocks the stream (strict order, no skipping).
    assign w_deliver  = (r_state == c_ST_SEND) && out_ready[r_cur_sel];
    assign w_in_ready = !reset && ((r_state == c_ST_IDLE) || w_deliver);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_data      <= '0;
            r_cur_sel   <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_stall_cnt <= '0;
            r_disp_cnt  <= '0;
        end else begin
            // Destination is captured at accept, so later cfg changes never
            // retarget a word that is already buffered.
            if (w_accept) begin
                r_state   <= c_ST_SEND;
                r_data    <= in_data;
                r_cur_sel <= cfg_mode ? cfg_sel : r_rr_ptr;
                if (!cfg_mode) begin
                    r_rr_ptr <= r_rr_ptr + 2'd1;
                end
            end else if (w_deliver) begin
                r_state <= c_ST_IDLE;
            end

            if (w_deliver) begin
                r_disp_cnt <= r_disp_cnt + CNT_W'(1);
            end

            if ((r_state == c_ST_IDLE) || w_deliver) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == c_ST_SEND) ? (4'b0001 << r_cur_sel) : 4'b0000;
    assign out_data  = r_data;
    assign cur_sel   = r_cur_sel;
    assign stall     = (r_stall_cnt == c_STALL_MAX);
    assign disp_cnt  = r_disp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmux4way_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmux4way_dispatcher
//  Description : Self-checking bench for dmux4way_dispatcher. Random stimulus
//                in phases (all-ready round-robin, fixed lane, one blocked
//                lane, fully random with resets) is compared every cycle
//                against a transaction-level model of the one-word buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux4way_dispatcher;

    localparam int WIDTH       = 8;
    localparam int STALL_LIMIT = 16;
    localparam int CNT_W       = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             cfg_mode;
    logic [1:0]       cfg_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       cur_sel;
    logic             stall;
    logic [CNT_W-1:0] disp_cnt;

    int n_checks;
    int n_fail;

    dmux4way_dispatcher #(
        .WIDTH       (WIDTH),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_mode  (cfg_mode),
        .cfg_sel   (cfg_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_sel   (cur_sel),
        .stall     (stall),
        .disp_cnt  (disp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a one-entry holding buffer with the word, its lane,
    // how long it has waited, plus the round-robin pointer and delivery count.
    bit m_full;
    int m_data;
    int m_lane;
    int m_rr;
    int m_wait;
    int m_cnt;

    task automatic model_reset();
        m_full = 0; m_data = 0; m_lane = 0; m_rr = 0; m_wait = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input int cyc);
        int exp_valid;
        int exp_ready;
        exp_valid = m_full ? (1 << m_lane) : 0;
        exp_ready = (!reset && (!m_full || out_ready[m_lane])) ? 1 : 0;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready",  32'(in_ready),  32'(exp_ready));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("cur_sel",   32'(cur_sel),   32'(m_lane));
        chk("stall",     32'(stall),     32'((m_wait >= STALL_LIMIT) ? 1 : 0));
        chk("disp_cnt",  32'(disp_cnt),  32'(m_cnt));
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit acc;
        bit dlv;
        if (reset) begin
            model_reset();
        end else begin
            dlv = m_full && out_ready[m_lane];
            acc = in_valid && (!m_full || dlv);
            if (dlv) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (!m_full || dlv) m_wait = 0;
            else if (m_wait < STALL_LIMIT) m_wait = m_wait + 1;
            if (acc) begin
                m_full = 1;
                m_data = int'(in_data);
                m_lane = cfg_mode ? int'(cfg_sel) : m_rr;
                if (!cfg_mode) m_rr = (m_rr + 1) % 4;
            end else if (dlv) begin
                m_full = 0;
            end
        end
    endtask

    initial begin
        int kind;
        int blk_lane;
        int fix_sel;
        n_checks = 0;
        n_fail   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_mode  = 1'b0;
        cfg_sel   = 2'd0;
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        model_reset();

        for (int ph = 0; ph < 28; ph++) begin
            kind     = ph % 4;
            blk_lane = $urandom_range(0, 3);
            fix_sel  = $urandom_range(0, 3);
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                reset    = (ph == 0 && cyc == 0);
                in_data  = WIDTH'($urandom);
                case (kind)
                    0: begin
                        in_valid  = 1'b1;
                        out_ready = 4'hF;
                        cfg_mode  = 1'b0;
                        cfg_sel   = 2'($urandom);
                    end
                    1: begin
                        in_valid  = 1'b1;
                        out_ready = 4'hF;
                        cfg_mode  = 1'b1;
                        cfg_sel   = 2'(fix_sel);
                    end
                    2: begin
                        in_valid  = ($urandom_range(0, 3) != 0);
                        cfg_mode  = ($urandom_range(0, 1) == 1);
                        cfg_sel   = 2'($urandom);
                        out_ready = (cyc < 28) ? (4'hF & ~(4'b0001 << blk_lane)) : 4'hF;
                    end
                    default: begin
                        in_valid  = ($urandom_range(0, 1) == 1);
                        cfg_mode  = ($urandom_range(0, 1) == 1);
                        cfg_sel   = 2'($urandom);
                        out_ready = 4'($urandom);
                        reset     = ($urandom_range(0, 31) == 0);
                    end
                endcase
                #1;
                check_outputs(cyc);
                @(posedge clk);
                model_step();
            end
        end

        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_outputs(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
